// File: rtl/div_share_arbiter_pkg.sv
// Shared types and helpers for the shared-divider arbiter: FSM encoding and
// the round-robin first-set search used to pick the next requester.
package div_share_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Index of the first set bit of valid at or after ptr, wrapping within nreq
  // (nreq <= 4). Returns ptr when nothing is valid; callers gate on |valid.
  function automatic logic [1:0] rr_first(input logic [3:0] valid,
                                          input logic [1:0] ptr,
                                          input int nreq);
    logic [1:0] idx;
    logic       found;
    int         k_idx;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      k_idx = (int'(ptr) + k) % nreq;
      if ((k < nreq) && !found && valid[k_idx]) begin
        idx   = 2'(k_idx);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// Request/response bundle between the requesters/consumer and the arbiter.
interface div_share_arbiter_if #(
  parameter int M    = 3,
  parameter int N    = 2,
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high. A requester may change a/b while valid and not yet ready;
  // only the operands present at the accepting edge are used. The arbiter holds
  // rsp_* stable while rsp_valid is high and rsp_ready is low.
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*M-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [M-N:0]      rsp_q;
  logic [N-1:0]      rsp_r;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err
  );
endinterface

// File: rtl/div_share_arbiter_divider.sv
// Combinational restoring divider for a normalised divisor (b[N-1]=1), giving
// an exact M-N+1 bit quotient; results for other divisors are meaningless.
module divider #(
  parameter int M = 3,
  parameter int N = 2
) (
  input  logic [M-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [M-N:0] o_q,
  output logic [N-1:0] o_r
);
  localparam int QW = M - N + 1;

  logic [N-1:0] w_rem;
  logic [N:0]   w_t;
  logic [QW-1:0] w_q;

  // The top N-1 dividend bits are always below a normalised divisor, so they
  // seed the partial remainder and only QW quotient bits need to be produced.
  always_comb begin
    w_rem = N'(i_a[M-1:QW]);
    w_t   = '0;
    w_q   = '0;
    for (int i = QW - 1; i >= 0; i--) begin
      w_t = {w_rem, i_a[i]};
      if (w_t >= {1'b0, i_b}) begin
        w_rem  = N'(w_t - {1'b0, i_b});
        w_q[i] = 1'b1;
      end else begin
        w_rem = N'(w_t);
      end
    end
  end

  assign o_q = w_q;
  assign o_r = w_rem;
endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one divider among NREQ requesters; one operation in
// flight, operands and results registered, responses tagged by requester id.
module div_share_arbiter
  import div_share_pkg::*;
#(
  parameter int M    = 3,
  parameter int N    = 2,
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic            clk,
  input  logic            rst,
  div_share_arbiter_if.slave bus,
  output state_t          o_dbg_state,
  output logic [IDW-1:0]  o_dbg_rr_ptr
);
  localparam int QW = M - N + 1;

  state_t          r_state;
  state_t          w_next_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [M-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [IDW-1:0]  r_id;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [QW-1:0]   r_rsp_q;
  logic [N-1:0]    r_rsp_r;
  logic            r_rsp_err;

  logic [IDW-1:0]  w_gnt;
  logic            w_any;
  logic            w_accept;
  logic [NREQ-1:0] w_req_ready;
  logic [QW-1:0]   w_q;
  logic [N-1:0]    w_r;
  logic            w_err;

  assign w_gnt = IDW'(rr_first(4'(bus.req_valid), 2'(r_rr_ptr), NREQ));
  assign w_any = |bus.req_valid;
  assign w_err = ~r_b[N-1];

  divider #(.M(M), .N(N)) u_divider (
    .i_a (r_a),
    .i_b (r_b),
    .o_q (w_q),
    .o_r (w_r)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Grant is offered only in IDLE and never while reset is asserted.
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = '0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst && w_any) begin
          w_req_ready[w_gnt] = 1'b1;
          w_accept           = |(bus.req_valid & w_req_ready);
        end
        if (w_accept) w_next_state = S_CALC;
      end
      S_CALC:  w_next_state = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= '0;
      r_rsp_r     <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= bus.req_a[w_gnt*M +: M];
        r_b      <= bus.req_b[w_gnt*N +: N];
        r_id     <= w_gnt;
        r_rr_ptr <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
      end
      // Unnormalised divisors report err with zeroed results.
      if (r_state == S_CALC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_err   <= w_err;
        r_rsp_q     <= w_err ? '0 : w_q;
        r_rsp_r     <= w_err ? '0 : w_r;
      end else if ((r_state == S_RESP) && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_q     = r_rsp_q;
  assign bus.rsp_r     = r_rsp_r;
  assign bus.rsp_err   = r_rsp_err;
  assign o_dbg_state   = r_state;
  assign o_dbg_rr_ptr  = r_rr_ptr;
endmodule
